// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, blanking constants and round-robin digit search for seg_scan_ctrl.
package seg_scan_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  localparam logic [3:0] ANODE_OFF = 4'hF;
  localparam logic [7:0] SEG_OFF   = 8'hFF;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
    logic       wrapped;
  } sel_t;

  // Searches cur_idx+1 .. cur_idx+4; landing on or past index 4 means the frame wrapped,
  // which also covers returning to a single enabled digit.
  function automatic sel_t next_enabled(input logic [1:0] cur_idx, input logic [3:0] digit_en);
    sel_t       r;
    logic [2:0] pos;
    r = '0;
    for (int off = 4; off >= 1; off--) begin
      pos = {1'b0, cur_idx} + 3'(off);
      if (digit_en[pos[1:0]]) begin
        r.found   = 1'b1;
        r.idx     = pos[1:0];
        r.wrapped = pos[2];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_pwm.sv
// rtl/seg_scan_pwm.sv - eight-slot dimming gate for one ON period; brightness captured at ON entry.
module seg_scan_pwm #(
  parameter int DWELL_CYCLES = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       active,
  input  logic [2:0] brightness,
  output logic       gate
);

  localparam int SLOT_CYCLES = DWELL_CYCLES / 8;

  logic [CNT_W-1:0] sub;
  logic [2:0]       slot;
  logic [2:0]       level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sub   <= '0;
      slot  <= '0;
      level <= 3'd7;
    end else if (start) begin
      sub   <= '0;
      slot  <= '0;
      level <= brightness;
    end else if (active) begin
      if (sub == CNT_W'(SLOT_CYCLES - 1)) begin
        sub  <= '0;
        slot <= slot + 3'd1;
      end else begin
        sub <= sub + 1'b1;
      end
    end
  end

  assign gate = active && (slot <= level);

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller with blanking and digit skipping.
// Optional PWM dimming under SEG_SCAN_PWM_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in_0,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [3:0] digit_en,
  input  logic [2:0] brightness,
  output logic [7:0] seg_out,
  output logic [3:0] anode,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx;
  logic             first, first_nx;
  logic             fd_q, fd_nx;
  logic [7:0]       pat, pat_nx;
  logic [7:0]       seg_sel;
  logic             on_entry;
  logic             do_sel;
  logic             gate;
  sel_t             sel;

  always_comb begin
    case (idx)
      2'd0:    seg_sel = seg_in_0;
      2'd1:    seg_sel = seg_in_1;
      2'd2:    seg_sel = seg_in_2;
      default: seg_sel = seg_in_3;
    endcase
  end

  assign sel = next_enabled(idx, digit_en);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    first_nx = first;
    fd_nx    = 1'b0;
    pat_nx   = pat;
    on_entry = 1'b0;
    do_sel   = 1'b0;
    case (state)
      IDLE: do_sel = 1'b1;
      BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          first_nx = 1'b0;
          // Only the post-reset visit can land on a disabled digit; reselect instead of lighting it.
          if (first && !digit_en[idx]) begin
            do_sel = 1'b1;
          end else begin
            state_nx = ON;
            cnt_nx   = '0;
            pat_nx   = seg_sel;
            on_entry = 1'b1;
          end
        end
      end
      ON: begin
        if (cnt == CNT_W'(DWELL_CYCLES - 1)) do_sel = 1'b1;
      end
      default: state_nx = BLANK;
    endcase
    if (do_sel) begin
      cnt_nx = '0;
      if (sel.found) begin
        state_nx = BLANK;
        idx_nx   = sel.idx;
        fd_nx    = sel.wrapped;
      end else begin
        state_nx = IDLE;
      end
    end
  end

`ifdef SEG_SCAN_PWM_EN
  seg_scan_pwm #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .CNT_W       (CNT_W)
  ) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .start     (on_entry),
    .active    (state == ON),
    .brightness(brightness),
    .gate      (gate)
  );
`else
  logic unused_brightness;
  assign unused_brightness = ^{brightness, on_entry};
  assign gate = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      first      <= 1'b1;
      fd_q       <= 1'b0;
      pat        <= SEG_OFF;
      seg_out    <= SEG_OFF;
      anode      <= ANODE_OFF;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      first      <= first_nx;
      fd_q       <= fd_nx;
      pat        <= pat_nx;
      seg_out    <= (state == ON) ? pat : SEG_OFF;
      anode      <= (state == ON && gate) ? ~(4'b0001 << idx) : ANODE_OFF;
      digit_idx  <= idx;
      frame_done <= fd_q;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

- Scan controller for the 4-digit seven-segment display.
- Time-multiplexes four 8-bit segment patterns onto one shared segment bus and four active-low anodes.
- Inserts a blanking gap between digits to suppress ghosting, skips disabled digits and optionally dims the display by PWM.
- Sits between the per-digit decoders and the board pins, replacing a free-running 2-bit scan counter.

## Interface
- DWELL_CYCLES, 100000: clock cycles a digit is lit per visit. Must be ≥8 and a multiple of 8.
- BLANK_CYCLES, 1000: cycles with all anodes off before each digit. Must be ≥1.
- CNT_W, 17: width of the dwell/blank counter. Must hold max(DWELL_CYCLES, BLANK_CYCLES)−1.
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- seg_in_0..seg_in_3  in  8 each  active-low segment patterns {dp,g..a} for digits 0..3.
- digit_en  in  4  bit i=1 includes digit i in the scan.
- brightness  in  3  duty level 0..7. Used only with SEG_SCAN_PWM_EN.
- seg_out  out  8  active-low segment bus; registered.
- anode  out  4  active-low digit select; bit i drives digit i; registered.
- digit_idx  out  2  index of the digit currently owning the bus.
- frame_done  out  1  one-cycle pulse at end of a full scan frame.

## Operation
- FSM states: IDLE, BLANK, ON.
- Reset values: state=BLANK, digit_idx=0, counters=0, anode=4'hF, seg_out=8'hFF, frame_done=0.
- BLANK state:
  - anode=4'hF, seg_out=8'hFF.
  - Lasts exactly BLANK_CYCLES cycles, then enters ON.
  - On entry to ON, seg_in_<digit_idx> is latched; changes to seg_in during ON are not shown until the next visit.
- ON state:
  - seg_out=latched pattern; anode has only bit digit_idx low, subject to PWM gating.
  - Lasts exactly DWELL_CYCLES cycles.
- Next-digit selection, at the last ON cycle:
  - Pick the next index with digit_en=1, searching round-robin from digit_idx+1 (wrapping 3→0). Combinational, no extra cycles.
  - If the search wraps past index 3, or returns the same single enabled digit, pulse frame_done in the cycle the new BLANK begins.
  - If no digit is enabled, go to IDLE. IDLE drives blank outputs and holds digit_idx.
- IDLE exits to BLANK on the first cycle any digit_en bit is 1, using the same round-robin search.
- Leaving reset: if digit_en[0]=0, the first BLANK is followed by a reselection instead of ON.
- digit_en changes mid-visit never truncate the current BLANK or ON; they take effect at the next selection.
- rst asserted mid-visit: all outputs return to reset values on the next edge; the latched pattern is discarded.

## Timing
- Outputs are registered and change one cycle after the state/counter change that causes them.
- With all four digits enabled, frame period = 4×(BLANK_CYCLES+DWELL_CYCLES) cycles. With k digits enabled it is k×(B+D).
- frame_done: exactly one pulse per frame, never asserted in IDLE.
- No cycle ever has two anodes low.
- A segment change never coincides with an anode low on a different digit, because BLANK separates the two.

## Configuration
- Macro SEG_SCAN_PWM_EN:
  - Defined: the ON period is split into 8 slots of DWELL_CYCLES/8 cycles each. The anode is driven low only in slots 0..brightness, giving duty (brightness+1)/8; brightness=7 is full on. seg_out stays valid for the whole ON period. brightness is sampled at ON entry.
  - Undefined: the anode is low for the entire ON period, brightness is ignored, and the slot logic is absent.

## Structure
- Package seg_scan_pkg:
  - state enum (IDLE, BLANK, ON).
  - constants ANODE_OFF=4'hF and SEG_OFF=8'hFF.
  - function next_enabled(cur_idx, digit_en) returning {found, idx, wrapped}.
- One sub-module, seg_scan_pwm: slot counter plus gate output, instantiated only under SEG_SCAN_PWM_EN.

## Test plan
All scenarios use DWELL_CYCLES=16 and BLANK_CYCLES=2.

- Reset, digit_en=4'hF, seg_in_i=8'h00+i → anodes cycle 1110, 1101, 1011, 0111. Each is low for 16 cycles, separated by 2 cycles of 1111/FF. frame_done pulses every 72 cycles.
- digit_en=4'b0101 → only digits 0 and 2 are scanned. Period 36 cycles; digit_idx never shows 1 or 3.
- digit_en→0 mid-ON of digit 1 → the digit-1 dwell completes, then IDLE with 1111/FF and no frame_done. digit_en=4'b1000 → BLANK for 2 cycles, then digit 3 lit.
- seg_in_0 changed from 8'hC0 to 8'hF9 mid-ON of digit 0 → seg_out holds 8'hC0 until the next visit to digit 0.
- SEG_SCAN_PWM_EN, brightness=2 → in each ON period the anode is low for cycles 0–5 and high for cycles 6–15. brightness=7 → low for all 16 cycles.
- rst pulsed at cycle 8 of ON of digit 2 → next edge gives anode=1111, seg_out=FF, digit_idx=0. The scan restarts with BLANK before digit 0.
